// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// {remainder, quotient} presented while ready_o is high.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic             neg_q_q, neg_r_q;

    logic [WIDTH-1:0] abs1, abs2, q_step, r_step;
    logic [WIDTH:0]   shifted, diff;
    logic             last_step;

    // Operand magnitudes; INT_MIN wraps to 2^(WIDTH-1) as an unsigned value
    always_comb begin
        abs1 = opdata1_i;
        abs2 = opdata2_i;
        if (signed_i && opdata1_i[WIDTH-1]) abs1 = -opdata1_i;
        if (signed_i && opdata2_i[WIDTH-1]) abs2 = -opdata2_i;
    end

    // One restoring shift-subtract step; diff[WIDTH] set means the trial borrowed
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        r_step  = shifted[WIDTH-1:0];
        q_step  = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            r_step = diff[WIDTH-1:0];
            q_step = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i)
                    state_d = (opdata2_i == '0) ? BYZERO : RUN;
            end
            BYZERO: state_d = annul_i ? IDLE : DONE;
            RUN: begin
                if (annul_i)        state_d = IDLE;
                else if (last_step) state_d = DONE;
            end
            DONE: begin
                if (annul_i || !start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath; sign correction is folded into the final RUN step
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        quo_q   <= abs1;
                        rem_q   <= '0;
                        dvs_q   <= abs2;
                        cnt_q   <= '0;
                        neg_q_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r_q <= signed_i & opdata1_i[WIDTH-1];
                    end
                end
                BYZERO: begin
                    quo_q <= '0;
                    rem_q <= '0;
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        quo_q <= neg_q_q ? -q_step : q_step;
                        rem_q <= neg_r_q ? -r_step : r_step;
                    end else begin
                        quo_q <= q_step;
                        rem_q <= r_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (state_q == DONE);
    assign result_o = ready_o ? {rem_q, quo_q} : '0;
    assign stall_o  = ((state_q == IDLE) && start_i && !annul_i)
                    || (state_q == BYZERO) || (state_q == RUN);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, sign handling, divide-by-zero,
// annul and mid-operation reset.
module tb_div_seq;

    localparam int unsigned WIDTH = 32;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stall_o;

    int n_checks = 0;
    int n_errors = 0;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full transaction: start, count cycles to ready, hold one DONE cycle, release
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int  lat;
        bit  stall_ok;
        logic [63:0] res;
        start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
        #1;
        check({tag, "_stall_req"}, 64'(stall_o), 64'd1);
        lat = 0;
        stall_ok = 1'b1;
        do begin
            tick();
            lat++;
            if (!ready_o && !stall_o) stall_ok = 1'b0;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom);
        end while (!ready_o && lat < 100);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        check({tag, "_result"}, result_o, exp_res);
        res = result_o;
        tick();
        check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_result"}, result_o, res);
        start_i = 1'b0;
        tick();
        check({tag, "_idle_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_idle_result"}, result_o, 64'd0);
        check({tag, "_idle_stall"}, 64'(stall_o), 64'd0);
    endtask

    task automatic expect_no_ready(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        tick();
        tick();
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        resetn = 1'b1;
        tick();

        run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 33);
        run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_div("divu_m7_2",   1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC}, 33);
        run_div("div_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000}, 33);
        run_div("divu_min_m1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0}, 33);
        run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD}, 33);
        run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF}, 33);
        run_div("divu_5_0",    1'b0, 32'd5,          32'd0,          64'd0, 2);
        run_div("div_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          64'd0, 2);

        // Annul and start together in IDLE: annul wins
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        #1;
        check("annul_idle_stall", 64'(stall_o), 64'd0);
        expect_no_ready("annul_idle_no_ready", 3);
        start_i = 1'b0; annul_i = 1'b0;
        tick();

        // Annul on the 10th RUN cycle
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        for (int i = 0; i < 10; i++) tick();
        check("annul_run_stall_pre", 64'(stall_o), 64'd1);
        annul_i = 1'b1;
        tick();
        check("annul_run_stall", 64'(stall_o), 64'd0);
        check("annul_run_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        expect_no_ready("annul_run_no_ready", 40);
        run_div("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Reset for one edge mid-RUN
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        for (int i = 0; i < 6; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1; start_i = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready_o), 64'd0);
        check("mid_rst_result", result_o, 64'd0);
        check("mid_rst_stall", 64'(stall_o), 64'd0);
        expect_no_ready("mid_rst_no_ready", 40);
        run_div("after_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
